// File: rtl/board_mode_arbiter_if.sv
// ============================================================================
// Module : board_mode_arbiter_if
// Brief  : Bundle between the mode arbiter and the three board sources
//          (mode button, per-source busy/serial bits, enables, shared line,
//          mode LEDs, switching indicator). When MODE_TIMEOUT_EN is defined
//          it also carries the sticky timeout_flag.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface board_mode_arbiter_if;
  logic       mode_btn;
  logic [2:0] src_busy;
  logic [2:0] src_out;
  logic [2:0] active;
  logic       out;
  logic [2:0] leds;
  logic       switching;
`ifdef MODE_TIMEOUT_EN
  logic       timeout_flag;
`endif

  // Arbiter side: consumes button and source status, drives enables and line.
  modport master (
    input  mode_btn, src_busy, src_out,
`ifdef MODE_TIMEOUT_EN
    output timeout_flag,
`endif
    output active, out, leds, switching
  );

  // Board side: the mirror image of the arbiter view.
  modport slave (
    output mode_btn, src_busy, src_out,
`ifdef MODE_TIMEOUT_EN
    input  timeout_flag,
`endif
    input  active, out, leds, switching
  );
endinterface

`default_nettype wire

// File: rtl/board_mode_arbiter.sv
// ============================================================================
// Module : board_mode_arbiter
// Brief  : Owns the shared serial line and mode select for keyboard (0),
//          wordboard (1) and tweetboard (2). A button press drains the current
//          frame, idles the line for GUARD_CYCLES, then enables the next mode.
//          Optional feature macro: MODE_TIMEOUT_EN (forced switch after
//          TIMEOUT_CYCLES of draining, sticky timeout_flag).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module board_mode_arbiter #(
  parameter int unsigned GUARD_CYCLES   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic        IDLE_LEVEL     = 1'b1
) (
  input  wire logic           sysclk,
  input  wire logic           reset,
  board_mode_arbiter_if.master bus
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_GUARD = 2'd2;

  localparam int unsigned GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

`ifdef MODE_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
`endif

  logic [1:0]    state, state_nxt;
  logic [1:0]    mode, mode_nxt;
  logic          btn_q;
  logic          req;
  logic [GW-1:0] gcnt;
  logic          busy_sel;
  logic          src_sel;
  logic          guard_done;
  logic          line_nxt;
  logic          out_q;
`ifdef MODE_TIMEOUT_EN
  logic [TW-1:0] tcnt;
  logic          tflag;
  logic          timed_out;
`endif

  // One-hot of a mode value; the unused encoding enables nothing.
  function automatic logic [2:0] onehot(input logic [1:0] m);
    case (m)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      2'd2:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  // Rising-edge request; btn_q resets high so a held button is not a press.
  assign req = bus.mode_btn & ~btn_q;

  // Status and data of the currently selected source only.
  always_comb begin
    busy_sel = 1'b0;
    src_sel  = IDLE_LEVEL;
    case (mode)
      2'd0: begin busy_sel = bus.src_busy[0]; src_sel = bus.src_out[0]; end
      2'd1: begin busy_sel = bus.src_busy[1]; src_sel = bus.src_out[1]; end
      2'd2: begin busy_sel = bus.src_busy[2]; src_sel = bus.src_out[2]; end
      default: begin busy_sel = 1'b0; src_sel = IDLE_LEVEL; end
    endcase
  end

  assign guard_done = (state == S_GUARD) && (gcnt == GUARD_LAST);

`ifdef MODE_TIMEOUT_EN
  assign timed_out = (state == S_DRAIN) && busy_sel && (tcnt == TIMEOUT_LAST);
`endif

  // Next mode in rotation 0->1->2->0; the illegal code recovers to 0.
  always_comb begin
    mode_nxt = mode;
    if (guard_done) begin
      case (mode)
        2'd0:    mode_nxt = 2'd1;
        2'd1:    mode_nxt = 2'd2;
        default: mode_nxt = 2'd0;
      endcase
    end
  end

  // State and datapath registers, all reset synchronously to mode 0 / RUN.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state <= S_RUN;
      mode  <= 2'd0;
      btn_q <= 1'b1;
      gcnt  <= '0;
      out_q <= IDLE_LEVEL;
`ifdef MODE_TIMEOUT_EN
      tcnt  <= '0;
      tflag <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      mode  <= mode_nxt;
      btn_q <= bus.mode_btn;
      out_q <= line_nxt;
      gcnt  <= (state == S_GUARD && !guard_done) ? gcnt + 1'b1 : '0;
`ifdef MODE_TIMEOUT_EN
      tcnt  <= (state == S_DRAIN && busy_sel && !timed_out) ? tcnt + 1'b1 : '0;
      if (timed_out) tflag <= 1'b1;
`endif
    end
  end

  // Next-state logic; presses outside RUN are simply not looked at.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN: begin
        if (req) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!busy_sel) state_nxt = S_GUARD;
`ifdef MODE_TIMEOUT_EN
        else if (timed_out) state_nxt = S_GUARD;
`endif
      end
      S_GUARD: begin
        if (guard_done) state_nxt = S_RUN;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  // Output decode: the selected source owns the line in RUN and DRAIN only.
  always_comb begin
    bus.active    = 3'b000;
    bus.switching = 1'b0;
    line_nxt      = IDLE_LEVEL;
    case (state)
      S_RUN: begin
        bus.active = onehot(mode);
        line_nxt   = src_sel;
      end
      S_DRAIN: begin
        bus.active    = onehot(mode);
        bus.switching = 1'b1;
        line_nxt      = src_sel;
      end
      S_GUARD: begin
        bus.switching = 1'b1;
      end
      default: begin
        bus.active = 3'b000;
      end
    endcase
  end

  assign bus.leds = onehot(mode);
  assign bus.out  = out_q;
`ifdef MODE_TIMEOUT_EN
  assign bus.timeout_flag = tflag;
`endif

endmodule

`default_nettype wire

// File: tb/tb_board_mode_arbiter.sv
// ============================================================================
// Module : tb_board_mode_arbiter
// Brief  : Directed and randomized bench for board_mode_arbiter against a
//          behavioural model of the mode-switch protocol.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_board_mode_arbiter;

  localparam int G = 16;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  // Behavioural model: mode, whether a switch is waiting on the frame, and
  // how many idle-line cycles remain before the next mode takes over.
  int   m_mode  = 0;
  bit   m_drain = 1'b0;
  int   m_guard = 0;
  bit   m_prev  = 1'b1;
  logic m_out   = 1'b1;

  board_mode_arbiter_if bus ();

  board_mode_arbiter #(
    .GUARD_CYCLES   (G),
    .TIMEOUT_CYCLES (100),
    .IDLE_LEVEL     (1'b1)
  ) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  // Advance one clock, update the model from the inputs held across the
  // edge, then compare every output one time unit later.
  task automatic step();
    bit req;
    @(posedge sysclk);
    if (reset) begin
      m_mode = 0; m_drain = 0; m_guard = 0; m_prev = 1; m_out = 1'b1;
    end else begin
      req    = bus.mode_btn && !m_prev;
      m_prev = bus.mode_btn;
      m_out  = (m_guard > 0) ? 1'b1 : bus.src_out[m_mode];
      if (m_guard > 0) begin
        m_guard--;
        if (m_guard == 0) m_mode = (m_mode + 1) % 3;
      end else if (m_drain) begin
        if (!bus.src_busy[m_mode]) begin
          m_drain = 0;
          m_guard = G;
        end
      end else if (req) begin
        m_drain = 1;
      end
    end
    #1;
    chk("active", bus.active, (m_guard > 0) ? 3'b000 : 3'(1 << m_mode));
    chk("leds", bus.leds, 3'(1 << m_mode));
    chk("out", {2'b00, bus.out}, {2'b00, m_out});
    chk("switching", {2'b00, bus.switching}, {2'b00, (m_drain || m_guard > 0)});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bus.mode_btn = 1'b0;
    bus.src_busy = 3'b000;
    bus.src_out  = 3'b111;

    // Reset held three cycles, then release.
    reset = 1'b1;
    steps(3);
    reset = 1'b0;
    step();
    chk("rst_active", bus.active, 3'b001);
    chk("rst_leds", bus.leds, 3'b001);
    chk("rst_out", {2'b00, bus.out}, 3'b001);
    chk("rst_switching", {2'b00, bus.switching}, 3'b000);
    steps(5);

    // Idle source: press, switching next edge, idle line for G cycles.
    bus.mode_btn = 1'b1;
    step();
    chk("t2_switching", {2'b00, bus.switching}, 3'b001);
    bus.mode_btn = 1'b0;
    step();
    chk("t2_active_off", bus.active, 3'b000);
    steps(G - 1);
    chk("t2_still_guard", bus.active, 3'b000);
    chk("t2_line_idle", {2'b00, bus.out}, 3'b001);
    step();
    chk("t2_active_new", bus.active, 3'b010);
    chk("t2_leds_new", bus.leds, 3'b010);

    // Busy source 1 holds the switch while its data passes through.
    bus.src_busy = 3'b010;
    bus.mode_btn = 1'b1;
    step();
    bus.mode_btn = 1'b0;
    for (int i = 0; i < 50; i++) begin
      bus.src_out = 3'($urandom_range(0, 7));
      step();
    end
    chk("t3_held", bus.active, 3'b010);
    bus.src_busy = 3'b000;
    bus.src_out  = 3'b111;
    steps(G + 2);
    chk("t3_next", bus.active, 3'b100);

    // Extra press mid-guard is dropped: one press, one step.
    steps(20);
    bus.mode_btn = 1'b1; step(); bus.mode_btn = 1'b0;
    steps(6);
    bus.mode_btn = 1'b1; step(); bus.mode_btn = 1'b0;
    steps(G + 5);
    chk("t4_wrap", bus.leds, 3'b001);

    // Reset mid-guard aborts the switch.
    bus.mode_btn = 1'b1; step(); bus.mode_btn = 1'b0;
    steps(5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_active", bus.active, 3'b001);
    chk("t5_switching", {2'b00, bus.switching}, 3'b000);
    steps(G + 4);
    chk("t5_no_switch", bus.leds, 3'b001);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      bus.mode_btn = ($urandom_range(0, 9) < 2);
      bus.src_busy = 3'($urandom_range(0, 7));
      bus.src_out  = 3'($urandom_range(0, 7));
      reset        = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
